// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives datapath selects, write strobes and the aluop code for the ALU
// decoder. Memory states stall on mem_ready. Unsupported opcodes raise a
// one-cycle illegal_op pulse in DECODE and return to FETCH.
// Outputs decode the current state. Where the FSM must react to mem_ready or
// zero in the same cycle (irwrite, pcen), that input also feeds the decode.
// Write strobes are gated by reset_n, so an asynchronous reset kills them at once.
module mc_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t state_r;
  state_t next_s;

  logic pcwrite_s;
  logic branch_s;
  logic memread_s;
  logic memwrite_s;
  logic irwrite_s;
  logic regwrite_s;
  logic illegal_s;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic, including memory stalls and opcode dispatch.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_s = S_DECODE;
        else           next_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_RTYPEEX;
          OP_BEQ:       next_s = S_BEQEX;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JEX;
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) next_s = S_MEMRD;
        else             next_s = S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready) next_s = S_MEMWB;
        else           next_s = S_MEMRD;
      end
      S_MEMWB:   next_s = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) next_s = S_FETCH;
        else           next_s = S_MEMWR;
      end
      S_RTYPEEX: next_s = S_RTYPEWB;
      S_RTYPEWB: next_s = S_FETCH;
      S_BEQEX:   next_s = S_FETCH;
      S_ADDIEX:  next_s = S_ADDIWB;
      S_ADDIWB:  next_s = S_FETCH;
      S_JEX:     next_s = S_FETCH;
      default:   next_s = S_FETCH;
    endcase
  end

  // Per-state output decode; anything not named in a state stays 0.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (state_r)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_s = 1'b0;
          default:                                       illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread_s = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord       = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Strobes are masked during reset so no partial write escapes after assertion.
  assign memread    = memread_s  & reset_n;
  assign memwrite   = memwrite_s & reset_n;
  assign irwrite    = irwrite_s  & reset_n;
  assign regwrite   = regwrite_s & reset_n;
  assign illegal_op = illegal_s  & reset_n;
  assign pcen       = (pcwrite_s | (branch_s & zero)) & reset_n;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each cycle's stimulus and the expected
// output vector are queued together, then applied and compared one per cycle.
module tb_mc_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, memread, memwrite, irwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic        z;
    logic [19:0] exp;
  } entry_t;

  entry_t sb[$];

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op), .state(state)
  );

  // Packs {state, pcen, memread, memwrite, irwrite, regwrite, illegal_op,
  // iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop}.
  function automatic logic [19:0] exp_out(input logic [3:0] st, input logic mr,
                                          input logic z, input logic [5:0] opv,
                                          input logic rstn);
    logic pw, br, rd, wr, ir, rw, il, io, mt, rdst, sa;
    logic [1:0] sb2, ps, ao;
    logic [3:0] s;
    pw = 1'b0; br = 1'b0; rd = 1'b0; wr = 1'b0; ir = 1'b0; rw = 1'b0; il = 1'b0;
    io = 1'b0; mt = 1'b0; rdst = 1'b0; sa = 1'b0; sb2 = 2'b00; ps = 2'b00; ao = 2'b00;
    s = rstn ? st : 4'd0;
    case (s)
      4'd0:  begin rd = 1'b1; sb2 = 2'b01; ir = mr; pw = mr; end
      4'd1:  begin
               sb2 = 2'b11;
               il = !(opv inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
             end
      4'd2:  begin sa = 1'b1; sb2 = 2'b10; end
      4'd3:  begin rd = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; mt = 1'b1; end
      4'd5:  begin wr = 1'b1; io = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  begin sa = 1'b1; sb2 = 2'b10; end
      4'd10: begin rw = 1'b1; end
      4'd11: begin ps = 2'b10; pw = 1'b1; end
      default: begin pw = 1'b0; end
    endcase
    if (!rstn) begin
      rd = 1'b0; ir = 1'b0; pw = 1'b0;
    end
    return {s, (pw | (br & z)), rd, wr, ir, rw, il, io, mt, rdst, sa, sb2, ps, ao};
  endfunction

  function automatic logic [19:0] observed();
    return {state, pcen, memread, memwrite, irwrite, regwrite, illegal_op,
            iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop};
  endfunction

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [5:0] opv, input logic mr, input logic z);
    entry_t e;
    e.op = opv; e.mr = mr; e.z = z;
    e.exp = exp_out(st, mr, z, opv, 1'b1);
    sb.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Queues one instruction: fs FETCH stall cycles, ms memory stall cycles.
  task automatic gen_instr(input logic [5:0] opv, input logic z, input int fs, input int ms);
    for (int i = 0; i < fs; i++) push(4'd0, opv, 1'b0, rb());
    push(4'd0, opv, 1'b1, rb());
    push(4'd1, opv, rb(), rb());
    case (opv)
      OP_LW: begin
        push(4'd2, opv, rb(), rb());
        for (int i = 0; i < ms; i++) push(4'd3, opv, 1'b0, rb());
        push(4'd3, opv, 1'b1, rb());
        push(4'd4, opv, rb(), rb());
      end
      OP_SW: begin
        push(4'd2, opv, rb(), rb());
        for (int i = 0; i < ms; i++) push(4'd5, opv, 1'b0, rb());
        push(4'd5, opv, 1'b1, rb());
      end
      OP_RTYPE: begin push(4'd6, opv, rb(), rb()); push(4'd7, opv, rb(), rb()); end
      OP_BEQ:   push(4'd8, opv, rb(), z);
      OP_ADDI:  begin push(4'd9, opv, rb(), rb()); push(4'd10, opv, rb(), rb()); end
      OP_J:     push(4'd11, opv, rb(), rb());
      default:  begin end
    endcase
  endtask

  // Applies queued stimulus at the falling edge and compares 1 ns later.
  task automatic run_stream(input string tag);
    entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; mem_ready = e.mr; zero = e.z;
      #1;
      check_eq(tag, observed(), e.exp);
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; op = 6'd0; mem_ready = 1'b1; zero = 1'b1;
    #1;
    check_eq("reset_hold", observed(), exp_out(4'd0, 1'b1, 1'b1, 6'd0, 1'b0));
    @(negedge clk);
    #1;
    check_eq("reset_edge", observed(), exp_out(4'd0, 1'b1, 1'b1, 6'd0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    gen_instr(OP_RTYPE, 1'b0, 0, 0);
    gen_instr(OP_LW,    1'b0, 0, 2);
    gen_instr(OP_BEQ,   1'b1, 0, 0);
    gen_instr(OP_BEQ,   1'b0, 0, 0);
    gen_instr(OP_SW,    1'b0, 0, 0);
    gen_instr(OP_ADDI,  1'b0, 0, 0);
    gen_instr(OP_J,     1'b0, 0, 0);
    gen_instr(6'b111111, 1'b0, 0, 0);
    gen_instr(OP_RTYPE, 1'b0, 2, 0);
    gen_instr(OP_SW,    1'b0, 1, 3);
    gen_instr(6'b000011, 1'b0, 0, 0);
    gen_instr(OP_LW,    1'b1, 1, 0);
    run_stream("instr");

    // Walk a store into a stalled MEMWR, then reset without a clock edge.
    push(4'd0, OP_SW, 1'b1, 1'b0);
    push(4'd1, OP_SW, 1'b1, 1'b0);
    push(4'd2, OP_SW, 1'b1, 1'b0);
    push(4'd5, OP_SW, 1'b0, 1'b0);
    run_stream("sw_pre_reset");
    #1;
    check_eq("memwr_stall", observed(), exp_out(4'd5, 1'b0, 1'b0, OP_SW, 1'b1));
    reset_n = 1'b0;
    #1;
    check_eq("async_reset", observed(), exp_out(4'd0, 1'b0, 1'b0, OP_SW, 1'b0));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_eq("reset_low_mr1", observed(), exp_out(4'd0, 1'b1, 1'b0, OP_SW, 1'b0));
    reset_n = 1'b1;

    gen_instr(OP_ADDI, 1'b0, 0, 0);
    gen_instr(OP_J,    1'b0, 0, 0);
    gen_instr(OP_BEQ,  1'b1, 1, 0);
    run_stream("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
